// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// The pipeline drives start/op/a/b; the unit returns busy/done/div_zero and HI/LO.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu (one bit per cycle, WIDTH+2 cycles start-to-result) plus mthi/mtlo.
// Requests arriving while busy or with an invalid op are dropped; the pipeline stalls on busy.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic             is_div_q, is_signed_q, sign_a_q, sign_b_q;
  logic [WIDTH-1:0] mag_a_q, mag_b_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dz_q;

  logic             op_valid, accept, sa, sb;
  logic [WIDTH-1:0] mag_a_n, mag_b_n;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, a_orig;
  logic             neg_res;

  assign op_valid = !(bus.op[2] && bus.op[1]);
  assign accept   = bus.start && (state_q == IDLE) && op_valid;
  // op[0]=0 selects the signed flavour of mult/div
  assign sa       = !bus.op[0] && bus.a[WIDTH-1];
  assign sb       = !bus.op[0] && bus.b[WIDTH-1];
  assign mag_a_n  = sa ? -bus.a : bus.a;
  assign mag_b_n  = sb ? -bus.b : bus.b;

  // Multiply: add multiplicand when the low multiplier bit is set, then shift right.
  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mag_a_q : {WIDTH{1'b0}})};
  // Divide: shift next dividend bit into the remainder and trial-subtract the divisor.
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_q};

  assign neg_res  = is_signed_q && (sign_a_q ^ sign_b_q);
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = sign_a_q ? -acc_hi_q : acc_hi_q;
  assign a_orig   = sign_a_q ? -mag_a_q : mag_a_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !bus.op[2]) state_d = CALC;
      CALC:    if (count_q == CW'(WIDTH-1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (bus.op[2]) begin
              if (bus.op[0]) lo_q <= bus.a;
              else           hi_q <= bus.a;
            end else begin
              is_div_q    <= bus.op[1];
              is_signed_q <= !bus.op[0];
              sign_a_q    <= sa;
              sign_b_q    <= sb;
              mag_a_q     <= mag_a_n;
              mag_b_q     <= mag_b_n;
              acc_hi_q    <= '0;
              acc_lo_q    <= bus.op[1] ? mag_a_n : mag_b_n;
              count_q     <= '0;
            end
          end
        end
        CALC: begin
          count_q <= count_q + CW'(1);
          if (!is_div_q) begin
            acc_hi_q <= mul_sum[WIDTH:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end else if (!div_diff[WIDTH]) begin
            acc_hi_q <= div_diff[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_q <= div_shift[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          done_q <= 1'b1;
          if (!is_div_q) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (mag_b_q == '0) begin
            hi_q <= a_orig;
            lo_q <= '1;
            dz_q <= 1'b1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed checks of muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eh, output logic [W-1:0] el, output logic ez);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ez = 1'b0;
    eh = '0;
    el = '0;
    case (op)
      3'd0: begin p = sa * sb; {eh, el} = p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {eh, el} = p; end
      default: begin
        if (b == 0) begin
          eh = a; el = '1; ez = 1'b1;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 32'd1;
      2: v = '1;
      3: v = 32'h8000_0000;
      4: v = 32'h7fff_ffff;
      5: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Called #1 after a rising edge; the request is accepted at the next edge.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    logic ez;
    int lat;
    bit got;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (op == 3'd4 || op == 3'd5) begin
      if (op == 3'd4) m_hi = a; else m_lo = a;
      check("mt_busy", bus.busy, 0);
      check("mt_done", bus.done, 0);
      check("mt_hi", bus.hi, m_hi);
      check("mt_lo", bus.lo, m_lo);
      return;
    end
    check("busy_after_accept", bus.busy, 1);
    model(op, a, b, eh, el, ez);
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      got = bus.done;
    end
    check("latency", lat, 33);
    check("res_hi", bus.hi, eh);
    check("res_lo", bus.lo, el);
    check("div_zero", bus.div_zero, ez);
    check("busy_at_done", bus.busy, 0);
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    int lat;
    bit got;
    int seen;
    bus.start = 1'b1; bus.op = 3'd0; bus.a = $urandom; bus.b = $urandom;
    #12;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dz", bus.div_zero, 0);
    bus.start = 1'b0;
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);

    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(3'd3, 32'd7, 32'd2);
    check("divu_small", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    do_op(3'd3, 32'h0000_1234, 32'd0);
    check("divu_zero", {bus.hi, bus.lo, 31'd0, bus.div_zero}, {64'h0000_1234_FFFF_FFFF, 32'd1});
    @(posedge clk); #1;
    check("done_clear", bus.done, 0);
    check("dz_clear", bus.div_zero, 0);

    do_op(3'd4, 32'hDEAD_BEEF, '0);
    do_op(3'd5, 32'h0123_4567, '0);
    for (int k = 6; k < 8; k++) begin
      bus.start = 1'b1; bus.op = 3'(k); bus.a = $urandom; bus.b = $urandom;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("inv_busy", bus.busy, 0);
      check("inv_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    end

    // Back-to-back random traffic: each request is offered in the cycle done is high.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) do_op(3'(r % 4), pick(), pick());
      else       do_op(3'(r - 4), pick(), pick());
    end

    // mthi offered mid-operation must be dropped.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("ign_hi_hold", bus.hi, m_hi);
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      got = bus.done;
    end
    check("ign_done", got, 1);
    check("ign_res", {bus.hi, bus.lo}, 64'd15);

    // Reset in the middle of a calculation.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd1; bus.a = $urandom; bus.b = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    check("abort_done", bus.done, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen++;
    end
    check("abort_quiet", seen, 0);
    check("abort_hilo_hold", {bus.hi, bus.lo}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the execute stage, sitting beside the 32-bit ALU and fed from the same operand buses. It executes mult, multu, div, divu (one result bit per cycle) and mthi/mtlo, holding results in architectural HI/LO registers. The ALU handles single-cycle ops; the pipeline stalls on `busy` for this unit's ops.

## Interface
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; accepted only at an edge where `busy`=0 and `op` is valid
- `op`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 11x invalid (request ignored)
- `a`  in  WIDTH  multiplicand / dividend / mthi-mtlo source
- `b`  in  WIDTH  multiplier / divisor
- `busy`  out  1  operation in progress; new requests ignored
- `done`  out  1  one-cycle pulse when HI/LO receive a mult/div result
- `div_zero`  out  1  one-cycle pulse with `done` when a div/divu had `b`=0
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE + accepted mult/div: latch op, operand signs, operand magnitudes (absolute values for signed ops, raw for unsigned), zero the partial accumulator, count<=0, busy<=1, go CALC.
- IDLE + accepted mthi/mtlo: write `a` to `hi`/`lo` at that edge; stay IDLE; `busy` and `done` stay 0.
- CALC: one iteration per cycle, count 0..WIDTH-1; after iteration WIDTH-1 go FIX.
  - Multiply: shift-add on magnitudes into a 2*WIDTH product.
  - Divide: restoring division on magnitudes; quotient 1 bit/cycle, remainder in accumulator.
- FIX: apply signs and write HI/LO, pulse `done`, `busy`<=0, go IDLE.
  - mult/multu: {hi,lo} = product; negate the 2*WIDTH product if signed and signs differ.
  - div/divu: lo = quotient, hi = remainder; quotient truncates toward zero (negated if signs differ), remainder takes the dividend's sign.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no trap).
  - Divisor zero (either signedness): still runs the full latency, then hi = original `a`, lo = all-ones, `div_zero`=1 with `done`.
- `start` while busy, or with invalid op: ignored with no side effects (no queueing).
- `hi`/`lo` hold value between writes; no other source modifies them.

## Timing
- Reset (async, `rst_n`=0): state IDLE, count 0, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, internal accumulators 0. Mid-CALC reset aborts immediately; HI/LO keep reset value 0.
- Accept edge E0: `busy` high after E0.
- CALC occupies edges E1..E32 (WIDTH edges); FIX at edge E33.
- After E33: `hi`/`lo` valid, `done`=1 for one cycle, `busy`=0. Latency WIDTH+2 = 34 cycles start-to-result.
- A new `start` is accepted at E34 (same cycle `done` is high): back-to-back throughput 1 op / 34 cycles.
- mthi/mtlo: value visible after the accepting edge; zero added latency.
- `done`/`div_zero` are registered; never high for more than one cycle and never high while `busy`=1.

## Test plan
- Reset: assert `rst_n`=0 with arbitrary inputs -> `hi`=`lo`=0, `busy`=`done`=`div_zero`=0; release, idle stable.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> after 34 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001, single `done` pulse; mult 0xFFFFFFFD x 7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- div 0xFFFFFFF9 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; divu 7 / 2 -> `lo`=3, `hi`=1; div 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- divu 0x00001234 / 0 -> after 34 cycles `hi`=0x00001234, `lo`=0xFFFFFFFF, `div_zero`=1 with `done`; next cycle both 0.
- mthi 0xDEADBEEF then mtlo 0x01234567 on consecutive edges -> `hi`/`lo` update at each edge, `busy`/`done` stay 0; op=110 with `start` -> no change.
- Start mult 3 x 5, pulse `start` (mthi 0xAAAAAAAA) at cycle 10 -> ignored, result `hi`=0 `lo`=15; restart, drop `rst_n` at cycle 20 -> immediate `busy`=0, `hi`=`lo`=0, no `done`.
